// File: rtl/in_ep_fifo_pkg.sv
// Shared definitions for the multi-packet IN endpoint buffer.
//   state_e : transaction state (idle between IN tokens / sourcing data)
//   clog2   : ceiling log2, used to size pointers and the packet counter
package in_ep_fifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/in_ep_ram.sv
// Simple dual-port byte RAM backing the IN endpoint buffer.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write byte
//   raddr_i : read address
//   rdata_o : read byte, combinational (distributed RAM, no reset)
module in_ep_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/in_ep_fifo.sv
// Multi-packet IN Bulk endpoint buffer between the application and the SIE.
// The application pushes bytes; the SIE pulls at most IN_MAXPACKETSIZE bytes
// per IN transaction through a speculative read pointer. Space is released
// only when the host ACKs, otherwise the next IN token replays the packet.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   usb_reset_i          : synchronous clear (bus reset)
//   app_in_data_i/valid_i/ready_o : application byte stream in
//   app_in_afull_o       : free space <= ALMOST_FULL_MARGIN
//   in_level_o/empty_o/full_o : committed occupancy and flags
//   in_data_o/valid_o    : byte stream to the SIE
//   in_req_i             : high for the duration of an IN transaction
//   in_ready_i           : SIE consume strobe
//   in_data_ack_i        : host ACKed the last packet
module in_ep_fifo
  import in_ep_fifo_pkg::*;
#(
  parameter int IN_MAXPACKETSIZE   = 8,
  parameter int BUFFER_DEPTH       = 32,
  parameter int ALMOST_FULL_MARGIN = 4,
  localparam int AW = clog2(BUFFER_DEPTH)
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        usb_reset_i,
  input  logic [7:0]  app_in_data_i,
  input  logic        app_in_valid_i,
  output logic        app_in_ready_o,
  output logic        app_in_afull_o,
  output logic [AW:0] in_level_o,
  output logic        in_empty_o,
  output logic        in_full_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_req_i,
  input  logic        in_ready_i,
  input  logic        in_data_ack_i
);

  localparam int PW = clog2(IN_MAXPACKETSIZE) + 1;

  state_e        state_q, state_d;
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [AW:0]   sp_q, sp_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          req_prev_q, req_prev_d;

  logic [AW:0]   level;
  logic [AW:0]   free_space;
  logic          full;
  logic          wr_en;
  logic          rd_fire;
  logic          req_rise;

  // The wrap bit makes wr - rd the true occupancy even when the low bits match.
  assign level      = wr_q - rd_q;
  assign free_space = (AW+1)'(BUFFER_DEPTH) - level;
  assign full       = (level == (AW+1)'(BUFFER_DEPTH));
  assign wr_en      = app_in_valid_i & ~full;
  assign req_rise   = in_req_i & ~req_prev_q;

  assign in_valid_o = (state_q == ST_DATA) && (sp_q != wr_q) &&
                      (pkt_cnt_q < PW'(IN_MAXPACKETSIZE));
  assign rd_fire    = in_valid_o & in_ready_i;

  assign app_in_ready_o = ~full;
  assign app_in_afull_o = (free_space <= (AW+1)'(ALMOST_FULL_MARGIN));
  assign in_level_o     = level;
  assign in_empty_o     = (level == '0);
  assign in_full_o      = full;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q + (AW+1)'(wr_en);
    // ACK commits everything read so far, regardless of state.
    rd_d       = in_data_ack_i ? sp_q : rd_q;
    sp_d       = sp_q;
    pkt_cnt_d  = pkt_cnt_q;
    req_prev_d = in_req_i;

    case (state_q)
      ST_IDLE: begin
        if (req_rise) begin
          // Rewind onto the post-ACK commit point so an ACK arriving with the
          // token is honoured before the replay decision.
          sp_d      = rd_d;
          pkt_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rd_fire) begin
          sp_d      = sp_q + (AW+1)'(1);
          pkt_cnt_d = pkt_cnt_q + PW'(1);
        end
        if (!in_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (usb_reset_i) begin
      state_d   = ST_IDLE;
      wr_d      = '0;
      rd_d      = '0;
      sp_d      = '0;
      pkt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      sp_q       <= '0;
      pkt_cnt_q  <= '0;
      req_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      sp_q       <= sp_d;
      pkt_cnt_q  <= pkt_cnt_d;
      req_prev_q <= req_prev_d;
    end
  end

  in_ep_ram #(
    .DEPTH (BUFFER_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_q[AW-1:0]),
    .wdata_i (app_in_data_i),
    .raddr_i (sp_q[AW-1:0]),
    .rdata_o (in_data_o)
  );

endmodule

// File: tb/tb_in_ep_fifo.sv
// Self-checking bench for in_ep_fifo (DEPTH 32, MPS 8, margin 4).
module tb_in_ep_fifo;

  localparam int DEPTH  = 32;
  localparam int MPS    = 8;
  localparam int MARGIN = 4;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       usb_reset_i = 1'b0;
  logic [7:0] app_in_data_i = 8'h00;
  logic       app_in_valid_i = 1'b0;
  logic       app_in_ready_o;
  logic       app_in_afull_o;
  logic [5:0] in_level_o;
  logic       in_empty_o;
  logic       in_full_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_req_i = 1'b0;
  logic       in_ready_i = 1'b0;
  logic       in_data_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  in_ep_fifo #(
    .IN_MAXPACKETSIZE   (MPS),
    .BUFFER_DEPTH       (DEPTH),
    .ALMOST_FULL_MARGIN (MARGIN)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .usb_reset_i    (usb_reset_i),
    .app_in_data_i  (app_in_data_i),
    .app_in_valid_i (app_in_valid_i),
    .app_in_ready_o (app_in_ready_o),
    .app_in_afull_o (app_in_afull_o),
    .in_level_o     (in_level_o),
    .in_empty_o     (in_empty_o),
    .in_full_o      (in_full_o),
    .in_data_o      (in_data_o),
    .in_valid_o     (in_valid_o),
    .in_req_i       (in_req_i),
    .in_ready_i     (in_ready_i),
    .in_data_ack_i  (in_data_ack_i)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: committed bytes as a queue, plus how many of them the
  // current/last packet has handed out and whether an IN transaction is open.
  logic [7:0] mq[$];
  int spec_n = 0;
  int pkt_n = 0;
  bit tx = 0;
  bit req_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    spec_n = 0;
    pkt_n = 0;
    tx = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the
  // model with this cycle's inputs, then step to just after the next edge.
  task automatic cycle(input bit wv, input logic [7:0] wd, input bit req,
                       input bit rdy, input bit ack, input bit usb);
    int sz;
    bit exp_valid;
    int commit;
    bit rd_fire;
    bit wr_ok;
    app_in_valid_i = wv;
    app_in_data_i  = wd;
    in_req_i       = req;
    in_ready_i     = rdy;
    in_data_ack_i  = ack;
    usb_reset_i    = usb;

    sz = mq.size();
    exp_valid = tx && (spec_n < sz) && (pkt_n < MPS);
    chk("m_level", 32'(in_level_o), 32'(sz));
    chk("m_valid", 32'(in_valid_o), 32'(exp_valid));
    chk("m_ready", 32'(app_in_ready_o), 32'(sz < DEPTH));
    chk("m_full", 32'(in_full_o), 32'(sz == DEPTH));
    chk("m_empty", 32'(in_empty_o), 32'(sz == 0));
    chk("m_afull", 32'(app_in_afull_o), 32'((DEPTH - sz) <= MARGIN));
    if (exp_valid) chk("m_data", 32'(in_data_o), 32'(mq[spec_n]));

    commit  = ack ? spec_n : 0;
    rd_fire = exp_valid && rdy;
    wr_ok   = wv && (sz < DEPTH);
    spec_n  = spec_n + int'(rd_fire) - commit;
    pkt_n   = pkt_n + int'(rd_fire);
    for (int i = 0; i < commit; i++) void'(mq.pop_front());
    if (wr_ok) mq.push_back(wd);
    if (!tx) begin
      if (req && !req_prev) begin
        tx = 1;
        spec_n = 0;
        pkt_n = 0;
      end
    end else if (!req) begin
      tx = 0;
    end
    if (usb) model_clear();
    req_prev = req;

    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    cycle(1, d, 0, 0, 0, 0);
  endtask

  // Full IN transaction: token, n consume strobes, optional ACK, token end.
  task automatic xfer(input int n, input bit do_ack);
    cycle(0, 8'h00, 1, 0, 0, 0);
    for (int k = 0; k < n; k++) cycle(0, 8'h00, 1, 1, 0, 0);
    if (do_ack) cycle(0, 8'h00, 1, 0, 1, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit         wv;
    logic [7:0] wd;
    bit         req;
    bit         rdy;
    bit         ack;
    int         e_level;
    bit         e_valid;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 8'h11, 0, 0, 0, 1, 0, 8'h00};
    vt[1] = '{1, 8'h22, 0, 0, 0, 2, 0, 8'h00};
    vt[2] = '{1, 8'h33, 1, 0, 0, 3, 1, 8'h11};
    vt[3] = '{0, 8'h00, 1, 1, 0, 3, 1, 8'h22};
    vt[4] = '{0, 8'h00, 1, 1, 0, 3, 1, 8'h33};
    vt[5] = '{0, 8'h00, 1, 1, 0, 3, 0, 8'h00};
    vt[6] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00};
    vt[7] = '{0, 8'h00, 0, 0, 0, 0, 0, 8'h00};

    // Reset
    rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(in_valid_o), 0);
    chk("rst_ready", 32'(app_in_ready_o), 1);
    chk("rst_empty", 32'(in_empty_o), 1);
    chk("rst_full", 32'(in_full_o), 0);
    chk("rst_level", 32'(in_level_o), 0);
    chk("rst_afull", 32'(app_in_afull_o), 0);

    // Table-driven short packet
    for (int i = 0; i < 8; i++) begin
      cycle(vt[i].wv, vt[i].wd, vt[i].req, vt[i].rdy, vt[i].ack, 0);
      chk("vec_level", 32'(in_level_o), 32'(vt[i].e_level));
      chk("vec_valid", 32'(in_valid_o), 32'(vt[i].e_valid));
      if (vt[i].e_valid) chk("vec_data", 32'(in_data_o), 32'(vt[i].e_data));
    end

    // 1: write 20 bytes
    for (int i = 0; i < 20; i++) wr(8'(i));
    chk("p1_level", 32'(in_level_o), 20);
    chk("p1_afull", 32'(app_in_afull_o), 0);
    chk("p1_empty", 32'(in_empty_o), 0);

    // 2: one packet of 8, ACK
    cycle(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("p2_valid", 32'(in_valid_o), 1);
      chk("p2_data", 32'(in_data_o), 32'(i));
      cycle(0, 8'h00, 1, 1, 0, 0);
    end
    chk("p2_limit", 32'(in_valid_o), 0);
    cycle(0, 8'h00, 1, 0, 1, 0);
    chk("p2_level", 32'(in_level_o), 12);
    cycle(0, 8'h00, 0, 0, 0, 0);

    // 3: packet without ACK is replayed
    cycle(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("p3_data1", 32'(in_data_o), 32'(8 + i));
      cycle(0, 8'h00, 1, 1, 0, 0);
    end
    cycle(0, 8'h00, 0, 0, 0, 0);
    chk("p3_noack_lvl", 32'(in_level_o), 12);
    cycle(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("p3_data2", 32'(in_data_o), 32'(8 + i));
      cycle(0, 8'h00, 1, 1, 0, 0);
    end
    cycle(0, 8'h00, 1, 0, 1, 0);
    chk("p3_level", 32'(in_level_o), 4);
    cycle(0, 8'h00, 0, 0, 0, 0);
    // Second ACK with nothing read commits nothing
    cycle(0, 8'h00, 0, 0, 1, 0);
    chk("p3_ack2", 32'(in_level_o), 4);
    xfer(4, 1);
    chk("p3_drain", 32'(in_level_o), 0);

    // 4: fill to full, almost-full boundary, overflow refused
    for (int k = 1; k <= 32; k++) begin
      wr(8'(8'h80 + k));
      if (k == 27) chk("p4_afull27", 32'(app_in_afull_o), 0);
      if (k == 28) chk("p4_afull28", 32'(app_in_afull_o), 1);
    end
    chk("p4_ready", 32'(app_in_ready_o), 0);
    chk("p4_full", 32'(in_full_o), 1);
    wr(8'hEE);
    chk("p4_no33", 32'(in_level_o), 32);
    for (int p = 0; p < 4; p++) xfer(8, 1);
    chk("p4_drain", 32'(in_level_o), 0);

    // 5: short packet extended by a mid-packet write
    for (int i = 0; i < 3; i++) wr(8'(8'h50 + i));
    chk("p5_level", 32'(in_level_o), 3);
    cycle(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("p5_data", 32'(in_data_o), 32'(8'h50 + i));
      cycle(0, 8'h00, 1, 1, 0, 0);
    end
    chk("p5_short", 32'(in_valid_o), 0);
    cycle(1, 8'hAA, 1, 0, 0, 0);
    chk("p5_ext_valid", 32'(in_valid_o), 1);
    chk("p5_ext_data", 32'(in_data_o), 32'h0AA);
    cycle(0, 8'h00, 1, 1, 0, 0);
    chk("p5_end", 32'(in_valid_o), 0);
    cycle(0, 8'h00, 1, 0, 1, 0);
    chk("p5_level0", 32'(in_level_o), 0);
    chk("p5_empty", 32'(in_empty_o), 1);
    cycle(0, 8'h00, 0, 0, 0, 0);

    // 6a: bus reset mid-transaction
    for (int i = 0; i < 10; i++) wr(8'(8'h60 + i));
    cycle(0, 8'h00, 1, 0, 0, 0);
    cycle(0, 8'h00, 1, 1, 0, 0);
    cycle(0, 8'h00, 1, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0, 1);
    chk("p6_usb_valid", 32'(in_valid_o), 0);
    chk("p6_usb_level", 32'(in_level_o), 0);
    cycle(0, 8'h00, 0, 0, 0, 0);

    // 6b: three full buffer cycles across the pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) wr(8'(r * 32 + i));
      chk("p6_full", 32'(in_full_o), 1);
      for (int p = 0; p < 4; p++) begin
        cycle(0, 8'h00, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
          chk("p6_wrap_data", 32'(in_data_o), 32'(8'(r * 32 + p * 8 + k)));
          cycle(0, 8'h00, 1, 1, 0, 0);
        end
        cycle(0, 8'h00, 1, 0, 1, 0);
        cycle(0, 8'h00, 0, 0, 0, 0);
      end
      chk("p6_wrap_lvl", 32'(in_level_o), 0);
    end

    // ACK together with a new token: replay starts after the ACKed bytes
    for (int i = 0; i < 12; i++) wr(8'(8'hC0 + i));
    cycle(0, 8'h00, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 8'h00, 1, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 1, 0);
    chk("ackrise_lvl", 32'(in_level_o), 4);
    chk("ackrise_data", 32'(in_data_o), 32'h0C8);
    cycle(0, 8'h00, 0, 0, 0, 0);

    // Asynchronous reset mid-packet discards everything
    cycle(0, 8'h00, 1, 0, 0, 0);
    cycle(0, 8'h00, 1, 1, 0, 0);
    in_req_i = 1'b0;
    in_ready_i = 1'b0;
    rstn_i = 1'b0;
    #2;
    chk("arst_level", 32'(in_level_o), 0);
    chk("arst_valid", 32'(in_valid_o), 0);
    chk("arst_empty", 32'(in_empty_o), 1);
    model_clear();
    req_prev = 0;
    #2;
    rstn_i = 1'b1;

    // Randomised traffic against the model
    begin
      bit req_r = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(7) == 0) req_r = ~req_r;
        cycle(($urandom_range(9) < 6), 8'($urandom), req_r,
              $urandom_range(1) == 1, $urandom_range(15) == 0,
              $urandom_range(499) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/in_ep_fifo.md
Name: in_ep_fifo

Overview:
- Parametrised multi-packet IN Bulk endpoint buffer; next generation of the single-packet IN FIFO behind the SIE.
- Holds up to BUFFER_DEPTH bytes, i.e. several packets; the application fills it from the clk_i domain.
- Sources at most IN_MAXPACKETSIZE bytes per IN transaction and frees data only on host ACK.
- An un-ACKed packet is rewound and retransmitted unchanged on the next IN token. Occupancy level and almost-full flag are exported.

Parameters:
IN_MAXPACKETSIZE, 8, max bytes per IN data packet (8/16/32/64)
BUFFER_DEPTH, 32, storage in bytes; power of two, >= IN_MAXPACKETSIZE
ALMOST_FULL_MARGIN, 4, app_in_afull_o asserts when free space <= this value

Ports:
clk_i  in  1  clock, 12MHz*BIT_SAMPLES
rstn_i  in  1  asynchronous active-low reset
usb_reset_i  in  1  synchronous clear while high (bus reset)
app_in_data_i  in  8  application byte
app_in_valid_i  in  1  app_in_data_i valid
app_in_ready_o  out  1  byte accepted when valid & ready
app_in_afull_o  out  1  free space <= ALMOST_FULL_MARGIN
in_level_o  out  AW+1  committed occupancy, AW = log2(BUFFER_DEPTH)
in_empty_o  out  1  committed occupancy == 0
in_full_o  out  1  committed occupancy == BUFFER_DEPTH
in_data_o  out  8  byte to SIE
in_valid_o  out  1  in_data_o valid
in_req_i  in  1  high for the duration of an IN transaction
in_ready_i  in  1  one-cycle consume strobe
in_data_ack_i  in  1  one-cycle pulse: host ACKed the last packet

Behaviour:
- Pointers are AW+1 bits with a wrap bit: wr_q (app write), rd_q (committed), sp_q (speculative read). Packet counter pkt_cnt_q counts 0..IN_MAXPACKETSIZE.
- Reset (rstn_i low, asynchronous) and usb_reset_i high (synchronous): all pointers 0, pkt_cnt_q 0, state IDLE.
- Output values in reset: in_valid_o 0, app_in_ready_o 1, in_empty_o 1, in_full_o 0, in_level_o 0, app_in_afull_o 0.
- Level: in_level_o = wr_q - rd_q, modulo 2^(AW+1). Free space = BUFFER_DEPTH - in_level_o.
- App write side:
  - app_in_ready_o = ~in_full_o.
  - On valid & ready: mem[wr_q[AW-1:0]] <= data, then wr_q++.
  - Space is reclaimed only by ACK, never by reading.
- Read data: in_data_o = mem[sp_q[AW-1:0]], combinational (distributed RAM). A byte written in cycle N is visible at in_data_o from cycle N+1.
- State machine:
  - IDLE: on in_req_i 0->1, set sp_q <= rd_q and pkt_cnt_q <= 0, then go to DATA. This rewinds any un-ACKed bytes.
  - DATA:
    - in_valid_o = (sp_q != wr_q) & (pkt_cnt_q < IN_MAXPACKETSIZE).
    - On in_valid_o & in_ready_i: sp_q++ and pkt_cnt_q++.
    - On in_req_i low: go to IDLE.
  - in_valid_o is 0 in IDLE.
- ACK:
  - On in_data_ack_i in any state: rd_q <= sp_q. This frees the bytes of the last packet in one cycle, and in_level_o drops the next cycle.
  - A second ACK without intervening reads commits nothing new.
- Short packet: if the FIFO drains before the limit, in_valid_o drops and the SIE ends the packet early. Bytes written mid-transaction may extend the packet up to the limit.
- Simultaneous events:
  - App write and SIE read in the same cycle are both performed.
  - App write and ACK in the same cycle: level = old + 1 - packet length.
  - in_req_i rising together with in_data_ack_i: ACK commits first, then the rewind uses the new rd_q, so sp_q = old sp_q.
- Full boundary: sp_q can never pass wr_q. wr_q can never exceed rd_q + BUFFER_DEPTH. Wrap handled by the wrap bit.
- Async reset mid-packet: the transaction is lost and all contents are discarded.

Decomposition:
- Package in_ep_fifo_pkg: state encoding (ST_IDLE, ST_DATA) and a clog2 function for AW.
- One sub-module in_ep_ram: BUFFER_DEPTHx8 simple dual-port RAM, synchronous write, asynchronous read, no reset.

Test Plan:
1. Reset, then write 20 bytes 0x00..0x13 (DEPTH 32, MPS 8) -> in_level_o=20; app_in_afull_o=0; in_empty_o=0.
2. in_req rises, SIE consumes 8, ACK -> in_data_o 0x00..0x07, in_valid_o low after 8th byte, in_level_o=12 one cycle after ACK.
3. in_req rises, 8 bytes read, in_req falls without ACK; in_req rises again -> resends 0x08..0x0F; after ACK, level=4.
4. Write 32 bytes into empty FIFO -> app_in_ready_o=0 and in_full_o=1 after 32nd; app_in_afull_o asserts at level 28; 33rd byte not accepted.
5. Level 3, in_req rises -> 3 bytes then in_valid_o=0 (short packet). Write 0xAA mid-packet -> in_valid_o returns with 0xAA; ACK -> level 0, in_empty_o=1.
6. usb_reset_i pulse at level 10 mid-transaction -> in_valid_o=0, in_level_o=0 next cycle. Pointer wrap over 3 full 32-byte cycles preserves byte order.
